// File: rtl/beep_seq_player.sv
// Score-driven buzzer player: steps through an 8-bit note RAM and drives an
// active-low PWM tone for each entry, with an end marker, looping and volume control.
module beep_seq_player #(
  parameter int CLK_PRE   = 50_000_000,
  parameter int BEAT_CYC  = 20_000_000,
  parameter int GAP_CYC   = 2_500_000,
  parameter int SEQ_DEPTH = 128,
  localparam int ADDR_W   = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        vol,
  output logic              pwm,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  // One spare bit above the lowest note's period so the octave-down shift fits.
  localparam int PW_RAW = $clog2(CLK_PRE / 523 + 1) + 1;
  localparam int PW     = (PW_RAW > 20) ? PW_RAW : 20;
  localparam int DW     = $clog2(4 * BEAT_CYC + 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SEQ_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        note_reg, note_next;
  logic [ADDR_W-1:0] note_idx_reg, note_idx_next;
  logic [PW-1:0]     tone_cnt_reg, tone_cnt_next;
  logic [DW-1:0]     dur_cnt_reg, dur_cnt_next;
  logic              pwm_reg, pwm_next;
  logic              done_reg, done_next;

  logic [7:0]        score [SEQ_DEPTH];
  logic [7:0]        entry;
  logic [PW-1:0]     base_p, peff, low_thr;
  logic [DW-1:0]     play_last;
  logic              tone_on, play_end, eos;

  function automatic logic [PW-1:0] base_period(input logic [3:0] n);
    case (n)
      4'd1:    base_period = PW'(CLK_PRE / 523);
      4'd2:    base_period = PW'(CLK_PRE / 587);
      4'd3:    base_period = PW'(CLK_PRE / 659);
      4'd4:    base_period = PW'(CLK_PRE / 698);
      4'd5:    base_period = PW'(CLK_PRE / 784);
      4'd6:    base_period = PW'(CLK_PRE / 880);
      4'd7:    base_period = PW'(CLK_PRE / 988);
      default: base_period = '0;
    endcase
  endfunction

  assign busy = (state_reg != IDLE);

  // Score edits are only accepted while the player is idle.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      score[wr_addr] <= wr_data;
    end
  end

  assign entry   = score[note_idx_reg];
  assign tone_on = (note_reg[3:0] != 4'd0) && (note_reg[3:0] < 4'd8);
  assign base_p  = base_period(note_reg[3:0]);

  always_comb begin
    case (note_reg[5:4])
      2'd0:    peff = base_p;
      2'd1:    peff = base_p >> 1;
      2'd2:    peff = base_p >> 2;
      default: peff = base_p << 1;
    endcase
  end

  always_comb begin
    case (vol)
      2'd1:    low_thr = peff >> 4;
      2'd2:    low_thr = peff >> 3;
      2'd3:    low_thr = peff >> 1;
      default: low_thr = '0;
    endcase
  end

  assign play_last = DW'((int'(note_reg[7:6]) + 1) * BEAT_CYC - GAP_CYC - 1);
  assign play_end  = (dur_cnt_reg == play_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      note_reg     <= '0;
      note_idx_reg <= '0;
      tone_cnt_reg <= '0;
      dur_cnt_reg  <= '0;
      pwm_reg      <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      note_reg     <= note_next;
      note_idx_reg <= note_idx_next;
      tone_cnt_reg <= tone_cnt_next;
      dur_cnt_reg  <= dur_cnt_next;
      pwm_reg      <= pwm_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    note_next     = note_reg;
    note_idx_next = note_idx_reg;
    tone_cnt_next = tone_cnt_reg;
    dur_cnt_next  = dur_cnt_reg;
    pwm_next      = 1'b1;
    done_next     = 1'b0;
    eos           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = LOAD;
          note_idx_next = '0;
        end
      end
      LOAD: begin
        note_next     = entry;
        tone_cnt_next = '0;
        dur_cnt_next  = '0;
        if (entry == 8'hFF) begin
          eos = 1'b1;
        end else begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (play_end) begin
          state_next   = GAP;
          dur_cnt_next = '0;
        end else begin
          dur_cnt_next = dur_cnt_reg + DW'(1);
        end
        if (tone_on) begin
          tone_cnt_next = (tone_cnt_reg >= peff - PW'(1)) ? '0 : tone_cnt_reg + PW'(1);
        end
        // The last PLAY cycle already drives high so GAP starts silent.
        if (tone_on && (vol != 2'd0) && !play_end) begin
          pwm_next = !(tone_cnt_reg < low_thr);
        end
      end
      GAP: begin
        if (dur_cnt_reg == GAP_LAST) begin
          dur_cnt_next = '0;
          if (note_idx_reg < IDX_LAST) begin
            state_next    = LOAD;
            note_idx_next = note_idx_reg + ADDR_W'(1);
          end else begin
            eos = 1'b1;
          end
        end else begin
          dur_cnt_next = dur_cnt_reg + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (eos) begin
      if (loop_en) begin
        state_next    = LOAD;
        note_idx_next = '0;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end

    // Abort wins over everything, including a start seen in the same cycle.
    if (stop) begin
      state_next    = IDLE;
      note_idx_next = note_idx_reg;
      tone_cnt_next = '0;
      dur_cnt_next  = '0;
      pwm_next      = 1'b1;
      done_next     = 1'b0;
    end
  end

  assign pwm      = pwm_reg;
  assign done     = done_reg;
  assign note_idx = note_idx_reg;

endmodule

// File: tb/tb_beep_seq_player.sv
// Scoreboard bench for beep_seq_player: stimulus queues expected events, a
// negedge monitor derives events from the DUT outputs and compares them in order.
module tb_beep_seq_player;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [1:0]    vol = 2'd3;
  logic          pwm, busy, done;
  logic [AW-1:0] note_idx;

  always #5 clk = ~clk;

  beep_seq_player #(
    .CLK_PRE(52300), .BEAT_CYC(1000), .GAP_CYC(100), .SEQ_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .vol(vol),
    .pwm(pwm), .busy(busy), .done(done), .note_idx(note_idx)
  );

  typedef enum int {E_RISE, E_IDX, E_FIRST, E_PER, E_LOW, E_BUSYLEN, E_TAIL,
                    E_DONE, E_DLEN, E_SNAP} ev_kind_t;
  typedef struct {ev_kind_t kind; int val;} ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  probe_req = 0;

  function automatic void expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_kind_t k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual %s=%0d, required none", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL %s: actual %s=%0d, required %s=%0d", e.kind.name(), k.name(), v,
                 e.kind.name(), e.val);
      end else begin
        $display("ok %s=%0d", k.name(), v);
      end
    end
  endtask

  // Monitor: every observable output change becomes one event.
  initial begin : monitor
    int ncyc = 0, last_start = 0, rise_cyc = 0, mark = 0;
    int last_fall = 0, last_rise = 0, done_cyc = 0, probe_ack = 0;
    bit first = 1'b0;
    logic pwm_d = 1'b1, busy_d = 1'b0, done_d = 1'b0;
    logic [AW-1:0] idx_d = '0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      ncyc++;
      if (busy && !busy_d) begin
        observe(E_RISE, ncyc - last_start);
        rise_cyc  = ncyc;
        last_rise = ncyc;
      end
      if (busy && (!busy_d || note_idx != idx_d)) begin
        observe(E_IDX, int'(note_idx));
        mark  = ncyc;
        first = 1'b1;
      end
      if (pwm_d && !pwm) begin
        if (first) observe(E_FIRST, ncyc - mark);
        else       observe(E_PER, ncyc - last_fall);
        first     = 1'b0;
        last_fall = ncyc;
      end
      if (!pwm_d && pwm) begin
        observe(E_LOW, ncyc - last_fall);
        last_rise = ncyc;
      end
      if (!busy && busy_d) begin
        observe(E_BUSYLEN, ncyc - rise_cyc);
        observe(E_TAIL, ncyc - last_rise);
      end
      if (done && !done_d) begin
        observe(E_DONE, int'(note_idx));
        done_cyc = ncyc;
      end
      if (!done && done_d) observe(E_DLEN, ncyc - done_cyc);
      if (probe_req != probe_ack) begin
        probe_ack = probe_req;
        observe(E_SNAP, int'({pwm, busy, done, note_idx}));
      end
      if (start) last_start = ncyc;
      pwm_d  = pwm;
      busy_d = busy;
      done_d = done;
      idx_d  = note_idx;
    end
  end

  task automatic wr(input int a, input int d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic snap(input int v);
    expect_ev(E_SNAP, v);
    probe_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_tone(input int per, input int low, input int n, input int last_low);
    expect_ev(E_FIRST, 2);
    expect_ev(E_LOW, (n == 1) ? last_low : low);
    for (int k = 1; k < n; k++) begin
      expect_ev(E_PER, per);
      expect_ev(E_LOW, (k == n - 1) ? last_low : low);
    end
  endtask

  task automatic exp_end(input int blen, input int tail, input int idx);
    expect_ev(E_BUSYLEN, blen);
    expect_ev(E_TAIL, tail);
    expect_ev(E_DONE, idx);
    expect_ev(E_DLEN, 1);
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    while (busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", limit);
    end
    repeat (4) @(negedge clk);
  endtask

  // Two-note score {01, 11, FF}: note 1 is one octave up at vol 3.
  task automatic exp_score_f_full();
    expect_ev(E_RISE, 1);
    expect_ev(E_IDX, 0);
    exp_tone(100, 50, 9, 50);
    expect_ev(E_IDX, 1);
    exp_tone(50, 25, 18, 25);
    expect_ev(E_IDX, 2);
    exp_end(2003, 125, 2);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    snap(32);

    // DO at vol 3; a start and a write during playback must be ignored.
    wr(0, 'h01); wr(1, 'hFF); vol = 2'd3;
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(100, 50, 9, 50);
    expect_ev(E_IDX, 1); exp_end(1002, 150, 1);
    do_start();
    repeat (300) @(posedge clk);
    #1 start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h01;
    @(posedge clk); #1 start = 1'b0; wr_en = 1'b0;
    wait_idle(3000);

    // Octave up, vol 1.
    wr(0, 'h11); wr(1, 'hFF); vol = 2'd1;
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(50, 3, 18, 3);
    expect_ev(E_IDX, 1); exp_end(1002, 147, 1);
    do_start(); wait_idle(3000);

    // Octave down, vol 3: the final low run is cut by the GAP.
    wr(0, 'h31); vol = 2'd3;
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(200, 100, 5, 99);
    expect_ev(E_IDX, 1); exp_end(1002, 101, 1);
    do_start(); wait_idle(3000);

    // Two-beat rest: silent throughout.
    wr(0, 'h40);
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0); expect_ev(E_IDX, 1);
    exp_end(2002, 2002, 1);
    do_start(); wait_idle(4000);

    // vol 2, then muted.
    wr(0, 'h01); vol = 2'd2;
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(100, 12, 9, 12);
    expect_ev(E_IDX, 1); exp_end(1002, 188, 1);
    do_start(); wait_idle(3000);
    vol = 2'd0;
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0); expect_ev(E_IDX, 1);
    exp_end(1002, 1002, 1);
    do_start(); wait_idle(3000);

    // Full score looped once, loop_en dropped during the second pass.
    for (int a = 0; a < 8; a++) wr(a, 'h01);
    vol = 2'd3; loop_en = 1'b1;
    expect_ev(E_RISE, 1);
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 8; j++) begin
        expect_ev(E_IDX, j);
        exp_tone(100, 50, 9, 50);
      end
    end
    exp_end(16016, 149, 7);
    do_start();
    repeat (10000) @(posedge clk);
    #1 loop_en = 1'b0;
    wait_idle(8000);

    // Stop during note 1, then start+stop together, then replay from 0.
    wr(0, 'h01); wr(1, 'h11); wr(2, 'hFF);
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(100, 50, 9, 50);
    expect_ev(E_IDX, 1); expect_ev(E_FIRST, 2); expect_ev(E_LOW, 25);
    expect_ev(E_BUSYLEN, 1041); expect_ev(E_TAIL, 13);
    do_start();
    repeat (1040) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    snap(33);
    exp_score_f_full();
    do_start(); wait_idle(4000);

    // Asynchronous reset mid-note while pwm is low; score survives reset.
    expect_ev(E_RISE, 1); expect_ev(E_IDX, 0);
    exp_tone(100, 50, 9, 50);
    expect_ev(E_IDX, 1); expect_ev(E_FIRST, 2); expect_ev(E_LOW, 25);
    expect_ev(E_PER, 50); expect_ev(E_LOW, 8);
    expect_ev(E_BUSYLEN, 1061); expect_ev(E_TAIL, 0);
    do_start();
    repeat (1061) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    snap(32);
    exp_score_f_full();
    do_start(); wait_idle(4000);

    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: actual none, required %s=%0d", e.kind.name(), e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beep_seq_player.md
BEEP_SEQ_PLAYER -- requirements
Module: beep_seq_player

Interface
REQ-001 SHALL have parameter CLK_PRE, default 50_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter BEAT_CYC, default 20_000_000: clk cycles per beat.
REQ-003 SHALL have parameter GAP_CYC, default 2_500_000: silent cycles at the end of each note; GAP_CYC < BEAT_CYC.
REQ-004 SHALL have parameter SEQ_DEPTH, default 128: score RAM entries; ADDR_W = clog2(SEQ_DEPTH).
REQ-005 SHALL have the following ports, clock and reset first (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  score write strobe
- wr_addr  in  ADDR_W  score write address
- wr_data  in  8  score entry
- start  in  1  begin playback
- stop  in  1  abort playback
- loop_en  in  1  repeat the score at its end
- vol  in  2  volume: 0 mute, 3 loudest
- pwm  out  1  buzzer drive; active-low, idle 1
- busy  out  1  playback active
- done  out  1  one-cycle pulse at a non-looped end
- note_idx  out  ADDR_W  index of the current entry

Function
REQ-006 SHALL decode entries as follows:
- [3:0] note: 0 rest, 1..7 DO,RE,MI,FA,SO,LA,SI (523,587,659,698,784,880,988 Hz); 8..14 treated as rest.
- [5:4] octave: 0 base, 1 up one, 2 up two, 3 down one.
- [7:6] len: the note lasts (len+1)*BEAT_CYC cycles.
REQ-007 SHALL treat entry 8'hFF as the end marker.
REQ-008 SHALL compute the base period as P = CLK_PRE/freq, truncated; the effective period is P, P>>1, P>>2 or P<<1 for octave 0..3; the period counter is at least 20 bits wide.
REQ-009 SHALL implement an FSM with states IDLE, LOAD, PLAY and GAP.
REQ-010 IDLE: pwm=1 and busy=0; a start pulse sets note_idx=0 and moves to LOAD on the next cycle.
REQ-011 LOAD: lasts exactly 1 cycle.
- Reads entry[note_idx] combinationally and latches it.
- Clears the tone and duration counters.
- Goes to PLAY, unless the entry is 8'hFF, which is handled as end-of-score.
REQ-012 PLAY: lasts (len+1)*BEAT_CYC - GAP_CYC cycles, then goes to GAP.
REQ-013 GAP: lasts GAP_CYC cycles with pwm=1.
- If note_idx < SEQ_DEPTH-1: go to LOAD with note_idx+1.
- Otherwise: end-of-score.
REQ-014 End-of-score:
- loop_en=1: note_idx=0, go to LOAD.
- loop_en=0: go to IDLE and assert done for 1 cycle.
- loop_en is sampled at the end-of-score cycle.
REQ-015 In PLAY, the tone counter SHALL count 0..Peff-1 and wrap.
REQ-016 In PLAY with a non-rest note, pwm SHALL be registered low while tone_cnt < Peff>>S, where S = 4, 3 or 1 for vol = 1, 2, 3, and high otherwise; pwm lags tone_cnt by 1 cycle.
REQ-017 pwm SHALL be held 1 for a rest, for vol=0, and in IDLE, LOAD and GAP.
REQ-018 vol SHALL be sampled every cycle, so volume changes take effect mid-note.
REQ-019 stop SHALL force IDLE on the next cycle from any state.
- pwm=1 and busy=0.
- No done pulse.
- stop has priority over a simultaneous start.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 wr_en SHALL write the score RAM only when busy=0; writes while busy=1 are dropped.
REQ-022 busy SHALL be 1 in LOAD, PLAY and GAP.
REQ-023 note_idx SHALL hold its value in IDLE.

Reset
REQ-024 Reset SHALL force IDLE with pwm=1, busy=0, done=0, note_idx=0 and all counters at 0, including mid-note.
REQ-025 Score RAM contents SHALL be unaffected by reset; the RAM is not initialised.

Verification
All scenarios use CLK_PRE=52300, BEAT_CYC=1000, GAP_CYC=100 and SEQ_DEPTH=8.
REQ-026 Write {8'h01, 8'hFF}, vol=3, start:
- busy rises 1 cycle after start.
- PLAY lasts 900 cycles, then 100 cycles of pwm=1.
- The end marker is handled in 1 cycle: done pulses 1 cycle, busy falls.
- During PLAY, pwm period is 100 cycles with 50 cycles low.
REQ-027 Write {8'h11, 8'hFF}, vol=1:
- Period is 50 cycles with 3 cycles low.
REQ-028 Write {8'h31, 8'hFF} then {8'h40, 8'hFF}:
- Low octave: period is 200 cycles.
- Rest with len=1: pwm=1 for all 2000 cycles; busy stays high.
REQ-029 All 8 entries 8'h01, loop_en=1:
- After entry 7's GAP, note_idx wraps to 0 and there is no done pulse.
- Then drop loop_en: done pulses after the next entry 7.
REQ-030 Assert stop in the middle of PLAY:
- Next cycle: pwm=1, busy=0, done=0.
- A subsequent start replays from index 0.
REQ-031 Assert rst_n low for 1 cycle in the middle of PLAY:
- pwm=1 and busy=0 immediately.
- start and wr_en issued while busy=1 have no effect.
